fetch_align: RTL and testbench
==============================

FETCH_ALIGN -- requirements
Module: fetch_align

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc_load  in  1  redirect strobe (branch/exception).
- pc_load_addr  in  64  redirect byte address; bit 0 ignored, treated as 0.
- mem_req  out  1  fetch request.
- mem_addr  out  64  fetch address, bits 2:0 always 0.
- mem_ready  in  1  transfer completes in any cycle with mem_req && mem_ready; mem_data valid that cycle.
- mem_data  in  64  fetched word; parcel 0 (lowest address) in bits 63:48, parcel 3 in bits 15:0.
- instOut  out  64  instruction window; current instruction left-aligned at bit 63.
- inst_valid  out  1  window holds the complete current instruction.
- pc  out  64  byte address of the instruction at instOut[63].
- advance16 / advance32 / advance64  in  1 each  consume 1 / 2 / 4 parcels from the decoder.
REQ-002 SHALL use a single clock, clk, with synchronous active-high reset, rst.

Function
REQ-003 SHALL hold a 128-bit left-aligned parcel buffer (8 x 16-bit parcels) with a parcel count, cnt, from 0 to 8.
REQ-004 SHALL drive instOut = buffer[127:64] combinationally; parcels beyond cnt read 0.
REQ-005 SHALL compute required length: instOut[63]=0 -> 1 parcel; [63:62]=10 -> 2; [63:62]=11 -> 4.
REQ-006 SHALL assert inst_valid = (cnt >= required length) combinationally; cnt=0 -> inst_valid=0.
REQ-007 SHALL honour advances only when inst_valid=1; if more than one is high, priority is 64 > 32 > 16; advances with inst_valid=0 SHALL be ignored.
REQ-008 SHALL consume k parcels on an honoured advance (k = 1/2/4): shift buffer left 16*k bits, cnt -= k, pc += 2*k (mod 2^64).
REQ-009 SHALL drive mem_req = 1 when cnt <= 4 and rst=0, else 0, based on registered state only (no combinational path from advance*).
REQ-010 SHALL keep a fetch pointer fa (8-byte aligned) driving mem_addr, and a skip count s (0..3).
REQ-011 SHALL, on a transfer, append parcels s..3 of mem_data at parcel position (cnt - k), cnt += 4 - s, fa += 8, s <= 0.
REQ-012 SHALL allow an advance and an append in the same cycle: new cnt = cnt - k + (4 - s); cnt never exceeds 8.
REQ-013 SHALL, on pc_load, give it priority over all other events that cycle: flush buffer (cnt=0), pc <= {pc_load_addr[63:1],0}, fa <= {pc_load_addr[63:3],000}, s <= pc_load_addr[2:1]; any same-cycle transfer data and advance are discarded.
REQ-014 SHALL, after pc_load in cycle N, present mem_req=1 with the new fa in cycle N+1; if mem_ready=1 in N+1, the instruction is available (inst_valid subject to REQ-006) in N+2.
REQ-015 SHALL treat mem_ready without mem_req as no transfer.
REQ-016 SHALL wrap fa and pc modulo 2^64 without error indication.

Reset
REQ-017 SHALL, while rst=1 at a clock edge, clear buffer, cnt, pc, fa and s to 0; outputs then read instOut=0, inst_valid=0, pc=0, mem_addr=0, mem_req=0 while rst=1.
REQ-018 SHALL, in the first cycle after rst falls, assert mem_req=1 with mem_addr=0.
REQ-019 SHALL let rst override pc_load, transfers and advances in the same cycle; a reset mid-fetch discards the in-flight word.

Verification
REQ-020 Reset then mem_ready=1, mem_data=0x1111_2222_3333_4444 -> next cycle instOut[63:0]=0x1111_2222_3333_4444, inst_valid=1, pc=0; advance16 -> instOut[63:48]=0x2222, pc=2.
REQ-021 Buffer holds a 64-bit instruction (instOut[63:62]=11) with cnt=2 -> inst_valid=0, advance64 ignored, pc unchanged; after a transfer, inst_valid=1.
REQ-022 pc_load_addr=0x1006 -> next cycle mem_addr=0x1000; data 0xAAAA_BBBB_CCCC_0123 -> instOut[63:48]=0x0123, cnt=1, pc=0x1006, next mem_addr=0x1008.
REQ-023 cnt=4, advance32 and transfer same cycle -> cnt=6, leftover two parcels followed by the four new ones, in order.
REQ-024 cnt=5 -> mem_req=0; advance16 -> cnt=4, mem_req=1 next cycle.
REQ-025 pc_load with mem_ready=1 and advance64 in same cycle -> data discarded, cnt=0, pc=new address, inst_valid=0.

Source files
------------

// File: rtl/fetch_align.sv
// fetch_align: instruction fetch alignment buffer.
//
// Fetches 64-bit words from memory and presents a left-aligned window of
// 16-bit parcels to the decoder. Instructions are 1, 2 or 4 parcels long,
// and the length is encoded in the top bits of the first parcel.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   pc_load, pc_load_addr    redirect strobe and target byte address
//   mem_req, mem_addr        fetch request and 8-byte aligned fetch address
//   mem_ready, mem_data      transfer handshake and fetched word (parcel 0 in [63:48])
//   instOut, inst_valid, pc  decode window, completeness flag, window byte address
//   advance16/32/64          decoder consumes 1/2/4 parcels
module fetch_align (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_load,
    input  logic [63:0] pc_load_addr,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ready,
    input  logic [63:0] mem_data,
    output logic [63:0] instOut,
    output logic        inst_valid,
    output logic [63:0] pc,
    input  logic        advance16,
    input  logic        advance32,
    input  logic        advance64
);

    logic [127:0] buf_q, buf_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [63:0]  pc_q,  pc_d;
    logic [63:0]  fa_q,  fa_d;
    logic [1:0]   s_q,   s_d;

    logic [2:0]   req_len;
    logic [2:0]   k;
    logic         xfer;
    logic [3:0]   cnt_mid;
    logic [127:0] shifted;
    logic [127:0] incoming;

    // Window is masked to the valid parcel count so stale data can never
    // leak into the decoder, independent of how the buffer got filled.
    always_comb begin
        instOut = 64'h0;
        for (int i = 0; i < 4; i++) begin
            if (4'(i) < cnt_q) begin
                instOut[63-16*i -: 16] = buf_q[127-16*i -: 16];
            end
        end
    end

    always_comb begin
        if (!instOut[63])      req_len = 3'd1;
        else if (!instOut[62]) req_len = 3'd2;
        else                   req_len = 3'd4;
    end

    assign inst_valid = (cnt_q != 4'd0) && (cnt_q >= {1'b0, req_len});

    // Request depends only on registered count, never on advance inputs.
    assign mem_req  = !rst && (cnt_q <= 4'd4);
    assign mem_addr = fa_q;
    assign pc       = pc_q;
    assign xfer     = mem_req && mem_ready;

    always_comb begin
        k = 3'd0;
        if (inst_valid) begin
            if (advance64)      k = 3'd4;
            else if (advance32) k = 3'd2;
            else if (advance16) k = 3'd1;
        end
    end

    always_comb begin
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        fa_d     = fa_q;
        s_d      = s_q;
        cnt_mid  = cnt_q - {1'b0, k};
        shifted  = buf_q << {k, 4'b0};
        // Skipped parcels are shifted out so the useful ones are left-aligned,
        // then the word is dropped in right behind the surviving parcels.
        incoming = {mem_data << {s_q, 4'b0}, 64'h0} >> {cnt_mid, 4'b0};

        if (rst) begin
            buf_d = 128'h0;
            cnt_d = 4'd0;
            pc_d  = 64'h0;
            fa_d  = 64'h0;
            s_d   = 2'd0;
        end else if (pc_load) begin
            buf_d = 128'h0;
            cnt_d = 4'd0;
            pc_d  = pc_load_addr & ~64'h1;
            fa_d  = pc_load_addr & ~64'h7;
            s_d   = pc_load_addr[2:1];
        end else begin
            buf_d = shifted;
            cnt_d = cnt_mid;
            pc_d  = pc_q + {60'h0, k, 1'b0};
            if (xfer) begin
                // cnt <= 4 whenever a transfer happens, so the result fits in 8.
                buf_d = shifted | incoming;
                cnt_d = cnt_mid + (4'd4 - {2'b0, s_q});
                fa_d  = fa_q + 64'd8;
                s_d   = 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
        cnt_q <= cnt_d;
        pc_q  <= pc_d;
        fa_q  <= fa_d;
        s_q   <= s_d;
    end

endmodule

// File: tb/tb_fetch_align.sv
module tb_fetch_align;

    logic        clk;
    logic        rst;
    logic        pc_load;
    logic [63:0] pc_load_addr;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ready;
    logic [63:0] mem_data;
    logic [63:0] instOut;
    logic        inst_valid;
    logic [63:0] pc;
    logic        advance16;
    logic        advance32;
    logic        advance64;

    fetch_align dut (
        .clk          (clk),
        .rst          (rst),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_data     (mem_data),
        .instOut      (instOut),
        .inst_valid   (inst_valid),
        .pc           (pc),
        .advance16    (advance16),
        .advance32    (advance32),
        .advance64    (advance64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] inst;
        logic        valid;
        logic [63:0] pcv;
        logic        req;
        logic [63:0] addr;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt;
    int   total_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    task automatic expect_st(input string tag, input logic [63:0] inst, input logic valid,
                             input logic [63:0] pcv, input logic req, input logic [63:0] addr);
        exp_t e;
        e.tag = tag; e.inst = inst; e.valid = valid; e.pcv = pcv; e.req = req; e.addr = addr;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".instOut"},    instOut,           e.inst);
            chk({e.tag, ".inst_valid"}, {63'h0, inst_valid}, {63'h0, e.valid});
            chk({e.tag, ".pc"},         pc,                e.pcv);
            chk({e.tag, ".mem_req"},    {63'h0, mem_req},  {63'h0, e.req});
            chk({e.tag, ".mem_addr"},   mem_addr,          e.addr);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic idle_inputs();
        pc_load = 0; pc_load_addr = 64'h0; mem_ready = 0; mem_data = 64'h0;
        advance16 = 0; advance32 = 0; advance64 = 0;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        rst = 1'b1;
        idle_inputs();
        #1;

        // Reset state
        expect_st("reset", 64'h0, 0, 64'h0, 0, 64'h0);
        step();

        // First cycle after reset: request at address 0
        rst = 1'b0;
        #1;
        expect_st("post_reset", 64'h0, 0, 64'h0, 1, 64'h0);
        drain();

        // Basic fill and advance16
        mem_ready = 1; mem_data = 64'h1111_2222_3333_4444;
        expect_st("fill0", 64'h1111_2222_3333_4444, 1, 64'h0, 1, 64'h8);
        step();
        idle_inputs(); advance16 = 1;
        expect_st("adv16", 64'h2222_3333_4444_0000, 1, 64'h2, 1, 64'h8);
        step();

        // Append at cnt=3 -> cnt=7, request drops
        idle_inputs(); mem_ready = 1; mem_data = 64'h5555_6666_7777_8888;
        expect_st("fill1", 64'h2222_3333_4444_5555, 1, 64'h2, 0, 64'h10);
        step();
        // mem_ready with no request: nothing happens
        expect_st("ready_no_req", 64'h2222_3333_4444_5555, 1, 64'h2, 0, 64'h10);
        step();
        // advance32 -> cnt=5, still no request, ready ignored
        advance32 = 1;
        expect_st("cnt5", 64'h4444_5555_6666_7777, 1, 64'h6, 0, 64'h10);
        step();
        // advance16 -> cnt=4, request returns
        idle_inputs(); mem_ready = 1; advance16 = 1;
        expect_st("cnt4_req", 64'h5555_6666_7777_8888, 1, 64'h8, 1, 64'h10);
        step();

        // Advance and append in the same cycle
        idle_inputs(); advance32 = 1; mem_ready = 1; mem_data = 64'h9999_AAAA_BBBB_CCCC;
        expect_st("adv_and_fill", 64'h7777_8888_9999_AAAA, 1, 64'hC, 0, 64'h18);
        step();
        idle_inputs(); advance32 = 1;
        expect_st("order", 64'h9999_AAAA_BBBB_CCCC, 1, 64'h10, 1, 64'h18);
        step();

        // Redirect into the middle of a word; 64-bit instruction split across words
        idle_inputs(); pc_load = 1; pc_load_addr = 64'h2004;
        expect_st("load2004", 64'h0, 0, 64'h2004, 1, 64'h2000);
        step();
        idle_inputs(); mem_ready = 1; mem_data = 64'h1234_5678_C000_1111;
        expect_st("long_partial", 64'hC000_1111_0000_0000, 0, 64'h2004, 1, 64'h2008);
        step();
        idle_inputs(); advance64 = 1;
        expect_st("adv64_ignored", 64'hC000_1111_0000_0000, 0, 64'h2004, 1, 64'h2008);
        step();
        idle_inputs(); mem_ready = 1; mem_data = 64'h2222_3333_4444_5555;
        expect_st("long_complete", 64'hC000_1111_2222_3333, 1, 64'h2004, 0, 64'h2010);
        step();
        idle_inputs(); advance64 = 1; advance16 = 1;
        expect_st("adv64_prio", 64'h4444_5555_0000_0000, 1, 64'h200C, 1, 64'h2010);
        step();

        // Redirect to 0x1006
        idle_inputs(); pc_load = 1; pc_load_addr = 64'h1006;
        expect_st("load1006", 64'h0, 0, 64'h1006, 1, 64'h1000);
        step();
        idle_inputs(); mem_ready = 1; mem_data = 64'hAAAA_BBBB_CCCC_0123;
        expect_st("skip3", 64'h0123_0000_0000_0000, 1, 64'h1006, 1, 64'h1008);
        step();

        // Redirect wins over transfer and advance
        idle_inputs(); pc_load = 1; pc_load_addr = 64'h3000;
        mem_ready = 1; mem_data = 64'hDEAD_BEEF_DEAD_BEEF; advance64 = 1;
        expect_st("load_prio", 64'h0, 0, 64'h3000, 1, 64'h3000);
        step();

        // Wrap-around at top of address space; bit 0 of redirect ignored
        idle_inputs(); pc_load = 1; pc_load_addr = 64'hFFFF_FFFF_FFFF_FFFD;
        expect_st("load_top", 64'h0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'hFFFF_FFFF_FFFF_FFF8);
        step();
        idle_inputs(); mem_ready = 1; mem_data = 64'h0000_0000_1234_5678;
        expect_st("fa_wrap", 64'h1234_5678_0000_0000, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h0);
        step();
        idle_inputs(); advance32 = 1;
        expect_st("pc_wrap", 64'h0, 0, 64'h0, 1, 64'h0);
        step();

        // Reset overrides redirect and transfer
        idle_inputs(); rst = 1; pc_load = 1; pc_load_addr = 64'h5000;
        mem_ready = 1; mem_data = 64'h1111_1111_1111_1111;
        expect_st("rst_prio", 64'h0, 0, 64'h0, 0, 64'h0);
        step();
        idle_inputs(); rst = 0;
        #1;
        expect_st("rst_release", 64'h0, 0, 64'h0, 1, 64'h0);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
